// File: rtl/write_dma_ahb_master_if.sv
// Bus bundle for the DMA write-path AHB-Lite initiator: command, source-buffer and AHB signals.
// WDMA_BUSY_INSERT_EN adds mem_RD_valid (source-data flow control).
interface write_dma_ahb_master_if #(
  parameter int BUF_AW = 4
) ();
  logic              start;
  logic [31:0]       start_addr;
  logic [4:0]        beat_count;
  logic [2:0]        burst_type;
  logic [BUF_AW-1:0] mem_RD_addr;
  logic [31:0]       mem_RD_data;
`ifdef WDMA_BUSY_INSERT_EN
  logic              mem_RD_valid;
`endif
  logic [31:0]       HADDR;
  logic [31:0]       HWDATA;
  logic              HWRITE;
  logic [2:0]        HBURST;
  logic [2:0]        HSIZE;
  logic [1:0]        HTRANS;
  logic              HREADY;
  logic              HRESP;
  logic              master_busy;
  logic              master_done;
  logic              dma_error;

  modport master (
`ifdef WDMA_BUSY_INSERT_EN
    input  mem_RD_valid,
`endif
    input  start, start_addr, beat_count, burst_type, mem_RD_data, HREADY, HRESP,
    output mem_RD_addr, HADDR, HWDATA, HWRITE, HBURST, HSIZE, HTRANS,
    output master_busy, master_done, dma_error
  );

  modport slave (
`ifdef WDMA_BUSY_INSERT_EN
    output mem_RD_valid,
`endif
    output start, start_addr, beat_count, burst_type, mem_RD_data, HREADY, HRESP,
    input  mem_RD_addr, HADDR, HWDATA, HWRITE, HBURST, HSIZE, HTRANS,
    input  master_busy, master_done, dma_error
  );
endinterface

// File: rtl/write_dma_ahb_master.sv
// AHB-Lite write-burst initiator for the DMA write path; one command in flight, 1KB-boundary safe.
// Optional WDMA_BUSY_INSERT_EN: stall on mem_RD_valid with BUSY (or IDLE before a NONSEQ).
module write_dma_ahb_master #(
  parameter int MAX_BEATS = 16,
  parameter int BUF_AW    = 4
) (
  input logic HCLK,
  input logic HRESET,
  write_dma_ahb_master_if.master bus
);
  localparam int BW = $clog2(MAX_BEATS) + 1;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3,
                         B_INCR8  = 3'd5, B_INCR16 = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DLAST, S_ERR} state_t;

  state_t      r_state;
  logic [31:0] r_haddr, r_hwdata;
  logic [1:0]  r_htrans, r_pend_tr;
  logic [2:0]  r_hburst;
  logic        r_hwrite, r_busy, r_done, r_err;
  logic        r_dph;    // a write data phase is on the bus this cycle
  logic        r_hold;   // waiting for source data before launching r_pend_tr
  logic [BW-1:0] r_beat, r_left;

  logic [BW-1:0] w_len;
  logic [2:0]    w_bt;
  logic [10:0]   w_end;
  logic          w_cross, w_err, w_src_ok;
  logic [31:0]   w_next_addr;
  logic [1:0]    w_next_tr;

  always_comb begin
    w_len = BW'(1);
    w_bt  = B_SINGLE;
    case (bus.burst_type)
      B_INCR: begin
        w_bt  = B_INCR;
        w_len = (int'(bus.beat_count) > MAX_BEATS) ? BW'(MAX_BEATS) : BW'(bus.beat_count);
      end
      B_INCR4:  begin w_bt = B_INCR4;  w_len = BW'(4);  end
      B_INCR8:  begin w_bt = B_INCR8;  w_len = BW'(8);  end
      B_INCR16: begin w_bt = B_INCR16; w_len = BW'(16); end
      default: ;
    endcase
  end

  // A burst whose last byte would land past the next 1KB line must be sent as INCR.
  assign w_end   = {1'b0, bus.start_addr[9:0]} + (11'(w_len) << 2);
  assign w_cross = w_end > 11'd1024;

  assign w_next_addr = r_haddr + 32'd4;
  assign w_next_tr   = (w_next_addr[9:0] == 10'd0) ? T_NSEQ : T_SEQ;
  assign w_err       = r_dph && bus.HRESP && !bus.HREADY;

`ifdef WDMA_BUSY_INSERT_EN
  assign w_src_ok = bus.mem_RD_valid;
`else
  assign w_src_ok = 1'b1;
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state   <= S_IDLE;
      r_haddr   <= '0;
      r_hwdata  <= '0;
      r_htrans  <= T_IDLE;
      r_pend_tr <= T_IDLE;
      r_hburst  <= B_SINGLE;
      r_hwrite  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_dph     <= 1'b0;
      r_hold    <= 1'b0;
      r_beat    <= '0;
      r_left    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (bus.HREADY) r_dph <= r_htrans[1];

      case (r_state)
        S_IDLE: begin
          if (bus.start && (w_len != '0)) begin
            r_state   <= S_ADDR;
            r_busy    <= 1'b1;
            r_hwrite  <= 1'b1;
            r_haddr   <= bus.start_addr;
            r_hburst  <= w_cross ? B_INCR : w_bt;
            r_beat    <= '0;
            r_left    <= w_len;
            r_pend_tr <= T_NSEQ;
            r_htrans  <= w_src_ok ? T_NSEQ : T_IDLE;
            r_hold    <= !w_src_ok;
          end
        end

        S_ADDR: begin
          if (w_err) begin
            r_state  <= S_ERR;
            r_htrans <= T_IDLE;
            r_haddr  <= '0;
            r_hold   <= 1'b0;
          end else if (bus.HREADY) begin
            if (r_hold) begin
              if (w_src_ok) begin
                r_htrans <= r_pend_tr;
                r_hold   <= 1'b0;
              end
            end else begin
              r_hwdata <= bus.mem_RD_data;
              if (r_left == BW'(1)) begin
                r_state  <= S_DLAST;
                r_htrans <= T_IDLE;
                r_haddr  <= '0;
              end else begin
                r_left    <= r_left - BW'(1);
                r_beat    <= r_beat + BW'(1);
                r_haddr   <= w_next_addr;
                r_pend_tr <= w_next_tr;
                if (w_next_tr == T_NSEQ) r_hburst <= B_INCR;
                // BUSY may only precede a SEQ; before a boundary NONSEQ we idle instead.
                if (w_src_ok)                r_htrans <= w_next_tr;
                else if (w_next_tr == T_SEQ) r_htrans <= T_BUSY;
                else                         r_htrans <= T_IDLE;
                r_hold <= !w_src_ok;
              end
            end
          end
        end

        S_DLAST: begin
          if (w_err) begin
            r_state <= S_ERR;
          end else if (bus.HREADY) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_hwrite <= 1'b0;
            r_beat   <= '0;
          end
        end

        S_ERR: begin
          if (bus.HREADY) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_err    <= 1'b1;
            r_hwrite <= 1'b0;
            r_beat   <= '0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_RD_addr = BUF_AW'(r_beat);
  assign bus.HADDR       = r_haddr;
  assign bus.HWDATA      = r_hwdata;
  assign bus.HWRITE      = r_hwrite;
  assign bus.HBURST      = r_hburst;
  assign bus.HSIZE       = 3'b010;
  assign bus.HTRANS      = r_htrans;
  assign bus.master_busy = r_busy;
  assign bus.master_done = r_done;
  assign bus.dma_error   = r_err;
endmodule

// File: tb/tb_write_dma_ahb_master.sv
// Directed bench for write_dma_ahb_master: a small write-capture monitor plus per-scenario tasks.
// Define WDMA_BUSY_INSERT_EN for both RTL and bench to cover the BUSY-insertion path.
module tb_write_dma_ahb_master;
  logic HCLK, HRESET;
  logic [31:0] buf_mem [16];
  int total = 0, bad = 0;

  logic [31:0] wr_addr[$], wr_data[$];
  logic        ph_v = 1'b0;
  logic [31:0] ph_a = '0;

  write_dma_ahb_master_if #(.BUF_AW(4)) bus ();
  write_dma_ahb_master #(.MAX_BEATS(16), .BUF_AW(4)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));

  assign bus.mem_RD_data = buf_mem[bus.mem_RD_addr];

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Slave side: log every completed write data phase as (address, data).
  always @(posedge HCLK) begin
    if (!HRESET && bus.HREADY) begin
      if (ph_v) begin
        wr_addr.push_back(ph_a);
        wr_data.push_back(bus.HWDATA);
      end
      ph_v = bus.HTRANS[1];
      ph_a = bus.HADDR;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic launch(input logic [31:0] a, input logic [2:0] bt, input logic [4:0] bc);
    bus.start = 1'b1; bus.start_addr = a; bus.burst_type = bt; bus.beat_count = bc;
    @(negedge HCLK);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.master_done !== 1'b1 && n < 40) begin
      @(negedge HCLK);
      n++;
    end
  endtask

  task automatic test_reset;
    HRESET = 1'b1; bus.start = 1'b0; bus.start_addr = '0; bus.beat_count = '0;
    bus.burst_type = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
`ifdef WDMA_BUSY_INSERT_EN
    bus.mem_RD_valid = 1'b1;
`endif
    for (int i = 0; i < 16; i++) buf_mem[i] = '0;
    repeat (2) @(negedge HCLK);
    total++; if (bus.HTRANS !== 2'b00) begin bad++; $display("FAIL rst_htrans got=%h exp=0", bus.HTRANS); end
    total++; if (bus.HADDR !== 32'h0) begin bad++; $display("FAIL rst_haddr got=%h exp=0", bus.HADDR); end
    total++; if (bus.HWDATA !== 32'h0) begin bad++; $display("FAIL rst_hwdata got=%h exp=0", bus.HWDATA); end
    total++; if (bus.HWRITE !== 1'b0) begin bad++; $display("FAIL rst_hwrite got=%b exp=0", bus.HWRITE); end
    total++; if (bus.HBURST !== 3'd0) begin bad++; $display("FAIL rst_hburst got=%h exp=0", bus.HBURST); end
    total++; if (bus.HSIZE !== 3'b010) begin bad++; $display("FAIL rst_hsize got=%h exp=2", bus.HSIZE); end
    total++; if ({bus.master_busy, bus.master_done, bus.dma_error} !== 3'b000)
      begin bad++; $display("FAIL rst_status got=%b exp=000", {bus.master_busy, bus.master_done, bus.dma_error}); end
    HRESET = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_single;
    int n;
    buf_mem[0] = 32'hA5A5A5A5;
    launch(32'h1000, 3'd0, 5'd0);
    total++; if (bus.HTRANS !== 2'b10) begin bad++; $display("FAIL single_c1_htrans got=%h exp=2", bus.HTRANS); end
    total++; if (bus.HADDR !== 32'h1000) begin bad++; $display("FAIL single_c1_haddr got=%h exp=1000", bus.HADDR); end
    total++; if (bus.HWRITE !== 1'b1 || bus.master_busy !== 1'b1)
      begin bad++; $display("FAIL single_c1_wr_busy got=%b%b exp=11", bus.HWRITE, bus.master_busy); end
    @(negedge HCLK);
    total++; if (bus.HTRANS !== 2'b00) begin bad++; $display("FAIL single_c2_htrans got=%h exp=0", bus.HTRANS); end
    total++; if (bus.HWDATA !== 32'hA5A5A5A5) begin bad++; $display("FAIL single_c2_hwdata got=%h exp=a5a5a5a5", bus.HWDATA); end
    total++; if (bus.master_done !== 1'b0) begin bad++; $display("FAIL single_c2_done got=%b exp=0", bus.master_done); end
    @(negedge HCLK);
    total++; if (bus.master_done !== 1'b1 || bus.dma_error !== 1'b0 || bus.master_busy !== 1'b0)
      begin bad++; $display("FAIL single_c3_done got=%b%b%b exp=100", bus.master_done, bus.dma_error, bus.master_busy); end
    @(negedge HCLK);
    wait_done(n);
    total++; if (n != 40) begin bad++; $display("FAIL single_done_repeat got=%0d exp=40", n); end
  endtask

  task automatic test_incr4;
    logic [31:0] ea [4] = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
    logic [1:0]  et [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
    logic [31:0] ed [4] = '{32'h11110000, 32'h22220001, 32'h33330002, 32'h44440003};
    for (int i = 0; i < 4; i++) buf_mem[i] = ed[i];
    launch(32'h2000, 3'd3, 5'd0);
    for (int c = 1; c <= 5; c++) begin
      if (c <= 4) begin
        total++; if (bus.HTRANS !== et[c-1] || bus.HADDR !== ea[c-1] || bus.HBURST !== 3'd3)
          begin bad++; $display("FAIL incr4_c%0d_addr got=%h/%h/%h exp=%h/%h/3", c, bus.HTRANS, bus.HADDR, bus.HBURST, et[c-1], ea[c-1]); end
      end else begin
        total++; if (bus.HTRANS !== 2'b00) begin bad++; $display("FAIL incr4_c5_htrans got=%h exp=0", bus.HTRANS); end
      end
      if (c >= 2) begin
        total++; if (bus.HWDATA !== ed[c-2]) begin bad++; $display("FAIL incr4_c%0d_hwdata got=%h exp=%h", c, bus.HWDATA, ed[c-2]); end
      end
      @(negedge HCLK);
    end
    total++; if (bus.master_done !== 1'b1) begin bad++; $display("FAIL incr4_c6_done got=%b exp=1", bus.master_done); end
    @(negedge HCLK);
  endtask

  task automatic test_incr8_wait;
    int n;
    for (int i = 0; i < 8; i++) buf_mem[i] = 32'hC0DE0000 + i;
    wr_addr.delete(); wr_data.delete();
    launch(32'h3000, 3'd5, 5'd0);
    repeat (3) @(negedge HCLK);
    total++; if (bus.HTRANS !== 2'b11 || bus.HADDR !== 32'h300C || bus.HWDATA !== 32'hC0DE0002)
      begin bad++; $display("FAIL incr8_c4 got=%h/%h/%h exp=3/300c/c0de0002", bus.HTRANS, bus.HADDR, bus.HWDATA); end
    bus.HREADY = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge HCLK);
      total++; if (bus.HTRANS !== 2'b11 || bus.HADDR !== 32'h300C || bus.HWDATA !== 32'hC0DE0002)
        begin bad++; $display("FAIL incr8_hold%0d got=%h/%h/%h exp=3/300c/c0de0002", k, bus.HTRANS, bus.HADDR, bus.HWDATA); end
    end
    bus.HREADY = 1'b1;
    @(negedge HCLK);
    total++; if (bus.HADDR !== 32'h3010 || bus.HWDATA !== 32'hC0DE0003)
      begin bad++; $display("FAIL incr8_c7 got=%h/%h exp=3010/c0de0003", bus.HADDR, bus.HWDATA); end
    wait_done(n);
    total++; if (n != 5) begin bad++; $display("FAIL incr8_done_cycle got=%0d exp=12", n + 7); end
    total++; if (wr_addr.size() != 8) begin bad++; $display("FAIL incr8_wr_count got=%0d exp=8", wr_addr.size()); end
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      total++; if (wr_addr[i] !== 32'h3000 + 4*i || wr_data[i] !== 32'hC0DE0000 + i)
        begin bad++; $display("FAIL incr8_wr%0d got=%h/%h exp=%h/%h", i, wr_addr[i], wr_data[i], 32'h3000 + 4*i, 32'hC0DE0000 + i); end
    end
    @(negedge HCLK);
  endtask

  task automatic test_boundary;
    int n;
    logic [31:0] ea [6] = '{32'h43F8, 32'h43FC, 32'h4400, 32'h4404, 32'h4408, 32'h440C};
    logic [1:0]  et [6] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11};
    launch(32'h43F8, 3'd1, 5'd6);
    for (int c = 0; c < 6; c++) begin
      total++; if (bus.HTRANS !== et[c] || bus.HADDR !== ea[c] || bus.HBURST !== 3'd1)
        begin bad++; $display("FAIL bnd_incr6_b%0d got=%h/%h/%h exp=%h/%h/1", c, bus.HTRANS, bus.HADDR, bus.HBURST, et[c], ea[c]); end
      @(negedge HCLK);
    end
    @(negedge HCLK);
    total++; if (bus.master_done !== 1'b1) begin bad++; $display("FAIL bnd_incr6_done got=%b exp=1", bus.master_done); end
    @(negedge HCLK);
    // fixed INCR4 that would cross: sent as INCR with a NONSEQ at the new 1KB line
    launch(32'h53F8, 3'd3, 5'd0);
    total++; if (bus.HBURST !== 3'd1) begin bad++; $display("FAIL bnd_incr4x_hburst got=%h exp=1", bus.HBURST); end
    repeat (2) @(negedge HCLK);
    total++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h5400)
      begin bad++; $display("FAIL bnd_incr4x_c3 got=%h/%h exp=2/5400", bus.HTRANS, bus.HADDR); end
    wait_done(n);
    @(negedge HCLK);
    // INCR4 ending exactly on the line stays INCR4
    launch(32'h63F0, 3'd3, 5'd0);
    total++; if (bus.HBURST !== 3'd3) begin bad++; $display("FAIL bnd_incr4e_hburst got=%h exp=3", bus.HBURST); end
    repeat (3) @(negedge HCLK);
    total++; if (bus.HTRANS !== 2'b11 || bus.HADDR !== 32'h63FC)
      begin bad++; $display("FAIL bnd_incr4e_c4 got=%h/%h exp=3/63fc", bus.HTRANS, bus.HADDR); end
    wait_done(n);
    total++; if (n != 2) begin bad++; $display("FAIL bnd_incr4e_done got=%0d exp=2", n); end
    @(negedge HCLK);
  endtask

  task automatic test_error;
    wr_addr.delete(); wr_data.delete();
    launch(32'h5000, 3'd7, 5'd0);
    repeat (2) @(negedge HCLK);
    total++; if (bus.HTRANS !== 2'b11 || bus.HADDR !== 32'h5008)
      begin bad++; $display("FAIL err_c3 got=%h/%h exp=3/5008", bus.HTRANS, bus.HADDR); end
    bus.HREADY = 1'b0; bus.HRESP = 1'b1;
    @(negedge HCLK);
    total++; if (bus.HTRANS !== 2'b00) begin bad++; $display("FAIL err_c4_htrans got=%h exp=0", bus.HTRANS); end
    total++; if (bus.master_done !== 1'b0) begin bad++; $display("FAIL err_c4_done got=%b exp=0", bus.master_done); end
    bus.HREADY = 1'b1;
    @(negedge HCLK);
    bus.HRESP = 1'b0;
    total++; if (bus.master_done !== 1'b1 || bus.dma_error !== 1'b1 || bus.master_busy !== 1'b0)
      begin bad++; $display("FAIL err_c5_pulse got=%b%b%b exp=110", bus.master_done, bus.dma_error, bus.master_busy); end
    for (int k = 0; k < 4; k++) begin
      @(negedge HCLK);
      total++; if (bus.HTRANS !== 2'b00 || bus.dma_error !== 1'b0)
        begin bad++; $display("FAIL err_after%0d got=%h/%b exp=0/0", k, bus.HTRANS, bus.dma_error); end
    end
    total++; if (wr_addr.size() != 2) begin bad++; $display("FAIL err_wr_count got=%0d exp=2", wr_addr.size()); end
  endtask

  task automatic test_zero_len;
    launch(32'h6000, 3'd1, 5'd0);
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.HTRANS !== 2'b00 || bus.master_busy !== 1'b0 || bus.master_done !== 1'b0)
        begin bad++; $display("FAIL zero_c%0d got=%h/%b/%b exp=0/0/0", k, bus.HTRANS, bus.master_busy, bus.master_done); end
      @(negedge HCLK);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    wr_addr.delete(); wr_data.delete();
    launch(32'h7000, 3'd3, 5'd0);
    bus.start = 1'b1; bus.start_addr = 32'h9000; bus.burst_type = 3'd0;
    @(negedge HCLK);
    bus.start = 1'b0;
    total++; if (bus.HADDR !== 32'h7004 || bus.HBURST !== 3'd3)
      begin bad++; $display("FAIL b2b_ignore got=%h/%h exp=7004/3", bus.HADDR, bus.HBURST); end
    wait_done(n);
    total++; if (wr_addr.size() != 4 || wr_addr[3] !== 32'h700C)
      begin bad++; $display("FAIL b2b_wr got=%0d exp=4", wr_addr.size()); end
    launch(32'h7100, 3'd0, 5'd0);
    total++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h7100)
      begin bad++; $display("FAIL b2b_next got=%h/%h exp=2/7100", bus.HTRANS, bus.HADDR); end
    wait_done(n);
    @(negedge HCLK);
  endtask

  task automatic test_reset_mid;
    launch(32'hA000, 3'd3, 5'd0);
    @(negedge HCLK);
    HRESET = 1'b1;
    #1;
    total++; if (bus.HTRANS !== 2'b00 || bus.HADDR !== 32'h0 || bus.master_busy !== 1'b0 || bus.HWRITE !== 1'b0)
      begin bad++; $display("FAIL rstmid got=%h/%h/%b/%b exp=0/0/0/0", bus.HTRANS, bus.HADDR, bus.master_busy, bus.HWRITE); end
    @(negedge HCLK);
    HRESET = 1'b0;
    repeat (2) @(negedge HCLK);
    total++; if (bus.HTRANS !== 2'b00 || bus.master_done !== 1'b0)
      begin bad++; $display("FAIL rstmid_after got=%h/%b exp=0/0", bus.HTRANS, bus.master_done); end
  endtask

`ifdef WDMA_BUSY_INSERT_EN
  task automatic test_busy_insert;
    int n;
    for (int i = 0; i < 4; i++) buf_mem[i] = 32'hBEEF0000 + i;
    wr_addr.delete(); wr_data.delete();
    launch(32'h8000, 3'd3, 5'd0);
    bus.mem_RD_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      total++; if (bus.HTRANS !== 2'b01 || bus.HADDR !== 32'h8004)
        begin bad++; $display("FAIL busy_c%0d got=%h/%h exp=1/8004", k, bus.HTRANS, bus.HADDR); end
    end
    bus.mem_RD_valid = 1'b1;
    @(negedge HCLK);
    total++; if (bus.HTRANS !== 2'b11 || bus.HADDR !== 32'h8004)
      begin bad++; $display("FAIL busy_resume got=%h/%h exp=3/8004", bus.HTRANS, bus.HADDR); end
    wait_done(n);
    total++; if (wr_addr.size() != 4 || wr_data[3] !== 32'hBEEF0003 || wr_addr[1] !== 32'h8004)
      begin bad++; $display("FAIL busy_wr got=%0d exp=4", wr_addr.size()); end
    @(negedge HCLK);
    bus.mem_RD_valid = 1'b0;
    launch(32'h8100, 3'd0, 5'd0);
    total++; if (bus.HTRANS !== 2'b00 || bus.master_busy !== 1'b1)
      begin bad++; $display("FAIL busy_first got=%h/%b exp=0/1", bus.HTRANS, bus.master_busy); end
    bus.mem_RD_valid = 1'b1;
    @(negedge HCLK);
    total++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h8100)
      begin bad++; $display("FAIL busy_first_go got=%h/%h exp=2/8100", bus.HTRANS, bus.HADDR); end
    wait_done(n);
    @(negedge HCLK);
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_incr4;
    test_incr8_wait;
    test_boundary;
    test_error;
    test_zero_len;
    test_back_to_back;
    test_reset_mid;
`ifdef WDMA_BUSY_INSERT_EN
    test_busy_insert;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
